// File: rtl/cutie_pool_pkg.sv
// cutie_pool_pkg: shared types, thresholds and ternary helpers for the OCU pooling stage
package cutie_pool_pkg;
  typedef enum logic [1:0] {
    POOL_BYPASS = 2'd0,
    POOL_MAX    = 2'd1,
    POOL_AVG    = 2'd2
  } pool_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pool_state_e;

  typedef logic signed [1:0] tern_t;
  typedef logic signed [2:0] part_t;
  typedef logic signed [3:0] sum_t;

  localparam sum_t AVG_POS_TH = 4'sd2;
  localparam sum_t AVG_NEG_TH = -4'sd2;

  // Code 10 is not a legal ternary and decodes to zero
  function automatic part_t tern_to_part(input logic [1:0] code);
    return (code == 2'b01) ? 3'sd1 : (code == 2'b11) ? -3'sd1 : 3'sd0;
  endfunction

  function automatic part_t part_max(input part_t a, input part_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic part_t part_sum(input part_t a, input part_t b);
    return a + b;
  endfunction

  function automatic tern_t ternarize(input sum_t s);
    return (s >= AVG_POS_TH) ? 2'sb01 : (s <= AVG_NEG_TH) ? 2'sb11 : 2'sb00;
  endfunction
endpackage

// File: rtl/cutie_pool_fifo.sv
// cutie_pool_fifo: synchronous FIFO holding row partials, with usage count and clear
module cutie_pool_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] usage_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pointer wrap and occupancy update; clear wins over any push or pop
  always_comb begin
    wptr_d = push_i ? ((wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d = pop_i ? ((rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1) : rptr_q;
    cnt_d  = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array needs no reset; only entries below the count are ever read
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign usage_o = cnt_q;
  assign full_o  = cnt_q == CNT_W'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/cutie_ocu_pool_unit.sv
// cutie_ocu_pool_unit: streaming 2x2 bypass/max/avg pooling of ternary pixels
module cutie_ocu_pool_unit
  import cutie_pool_pkg::*;
#(
  parameter int N_CH       = 96,
  parameter int MAX_WIDTH  = 64,
  parameter int MAX_HEIGHT = 64,
  parameter int POOL_DEPTH = MAX_WIDTH / 2,
  parameter int CNT_W      = $clog2(POOL_DEPTH + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [1:0]                       mode_i,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]   width_i,
  input  logic [$clog2(MAX_HEIGHT+1)-1:0]  height_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             cfg_err_o,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [2*N_CH-1:0]                in_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [2*N_CH-1:0]                out_data_o,
  output logic [CNT_W-1:0]                 fifo_usage_o
);
  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int HW = $clog2(MAX_HEIGHT + 1);

  pool_state_e       state_q, state_d;
  pool_mode_e        mode_q, mode_d;
  logic [WW-1:0]     width_q, width_d, col_q, col_d;
  logic [HW-1:0]     height_q, height_d, row_q, row_d;
  logic [2*N_CH-1:0] pair_q, pair_d, out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic [3*N_CH-1:0] part_w, head_w;
  logic [2*N_CH-1:0] byp_w, pool_w;
  logic              cfg_bad, pool_en, in_ready, accept, last_col, last_row;
  logic              push, pop, drain_done, fifo_full, fifo_empty;

  assign cfg_bad    = width_i == '0 || height_i == '0 || width_i > WW'(MAX_WIDTH) ||
                      height_i > HW'(MAX_HEIGHT) || mode_i == 2'd3;
  assign pool_en    = mode_q != POOL_BYPASS;
  assign in_ready   = state_q == ST_RUN && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready;
  assign last_col   = col_q == width_q - 1'b1;
  assign last_row   = row_q == height_q - 1'b1;
  assign push       = accept && pool_en && col_q[0] && !row_q[0];
  assign pop        = accept && pool_en && col_q[0] && row_q[0];
  assign drain_done = state_q == ST_DRAIN && !out_valid_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    part_t a, b, hp, h, m;
    tern_t t;
    assign a  = tern_to_part(pair_q[2*c +: 2]);
    assign b  = tern_to_part(in_data_i[2*c +: 2]);
    assign hp = (mode_q == POOL_MAX) ? part_max(a, b) : part_sum(a, b);
    assign h  = head_w[3*c +: 3];
    assign m  = part_max(h, hp);
    assign t  = ternarize(sum_t'(h) + sum_t'(hp));
    assign part_w[3*c +: 3] = hp;
    assign byp_w[2*c +: 2]  = b[1:0];
    assign pool_w[2*c +: 2] = (mode_q == POOL_MAX) ? m[1:0] : t;
  end

  cutie_pool_fifo #(
    .WIDTH (3 * N_CH),
    .DEPTH (POOL_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (drain_done),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (part_w),
    .rdata_o (head_w),
    .usage_o (fifo_usage_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Frame sequencing, pixel position tracking and output register loading
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    width_d     = width_q;
    height_d    = height_q;
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    out_valid_d = out_valid_q && !out_ready_i;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) begin
        cfg_err_d = cfg_bad;
        if (!cfg_bad) begin
          state_d  = ST_RUN;
          mode_d   = pool_mode_e'(mode_i);
          width_d  = width_i;
          height_d = height_i;
          col_d    = '0;
          row_d    = '0;
          pair_d   = '0;
        end
      end
      ST_RUN: if (accept) begin
        col_d  = last_col ? '0 : col_q + 1'b1;
        row_d  = last_col ? row_q + 1'b1 : row_q;
        pair_d = last_col ? '0 : (col_q[0] ? pair_q : in_data_i);
        if (last_col && last_row) state_d = ST_DRAIN;
        if (!pool_en || pop) begin
          out_valid_d = 1'b1;
          out_data_d  = pool_en ? pool_w : byp_w;
        end
      end
      ST_DRAIN: if (!out_valid_q) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mode_q      <= POOL_BYPASS;
      width_q     <= '0;
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      width_q     <= width_d;
      height_q    <= height_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Legal frames never fill or underrun the row-partial FIFO
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && fifo_empty));

  assign busy_o      = state_q != ST_IDLE;
  assign done_o      = done_q;
  assign cfg_err_o   = cfg_err_q;
  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
endmodule

// File: tb/tb_cutie_ocu_pool_unit.sv
// tb_cutie_ocu_pool_unit: scoreboard bench for the 2x2 pooling stage
module tb_cutie_ocu_pool_unit;
  localparam int N_CH = 96;
  localparam int DW   = 2 * N_CH;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [6:0]    width = '0, height = '0;
  logic          busy, done, cfg_err, in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0, out_data;
  logic          out_valid, out_ready = 1'b1;
  logic [5:0]    usage;

  int tests = 0, fails = 0, cyc = 0, last_hs = 0, peak = 0, out_cnt = 0;
  logic          stall = 1'b0;
  logic [DW-1:0] hold = '0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] img [8][8];

  cutie_ocu_pool_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
    .width_i(width), .height_i(height), .busy_o(busy), .done_o(done),
    .cfg_err_o(cfg_err), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .fifo_usage_o(usage)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks hold under stall
  always @(negedge clk) begin
    if (!rst_n) stall = 1'b0;
    else begin
      if (int'(usage) > peak) peak = int'(usage);
      if (out_valid && stall) check("hold_stable", out_data, hold);
      if (out_valid && !out_ready) check("in_ready_stall", DW'(in_ready), '0);
      if (out_valid && out_ready) begin
        out_cnt++;
        last_hs = cyc + 1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %h want none", out_data);
        end else check("out_data", out_data, exp_q.pop_front());
      end
      stall = out_valid && !out_ready;
      hold  = out_data;
    end
  end

  function automatic int tv(input logic [1:0] c);
    return (c == 2'b01) ? 1 : (c == 2'b11) ? -1 : 0;
  endfunction

  function automatic logic [1:0] enc(input int v);
    return (v > 0) ? 2'b01 : (v < 0) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [1:0] code4(input int i);
    return (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : (i == 2) ? 2'b11 : 2'b10;
  endfunction

  task automatic fill_varied(input int seed);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        for (int ch = 0; ch < N_CH; ch++)
          img[r][c][2*ch +: 2] = code4((r * 7 + c * 3 + ch * 5 + seed) % 4);
  endtask

  task automatic clear_img;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = '0;
  endtask

  // Reference: direct 2x2 window evaluation over the stored image
  task automatic model(input logic [1:0] m, input int w, input int h);
    logic [DW-1:0] wd;
    if (m == 2'd0) begin
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          for (int ch = 0; ch < N_CH; ch++) wd[2*ch +: 2] = enc(tv(img[r][c][2*ch +: 2]));
          exp_q.push_back(wd);
        end
    end else begin
      for (int r = 0; r < h / 2; r++)
        for (int c = 0; c < w / 2; c++) begin
          for (int ch = 0; ch < N_CH; ch++) begin
            int v0, v1, v2, v3, s, mx;
            v0 = tv(img[2*r][2*c][2*ch +: 2]);
            v1 = tv(img[2*r][2*c+1][2*ch +: 2]);
            v2 = tv(img[2*r+1][2*c][2*ch +: 2]);
            v3 = tv(img[2*r+1][2*c+1][2*ch +: 2]);
            s  = v0 + v1 + v2 + v3;
            mx = v0;
            if (v1 > mx) mx = v1;
            if (v2 > mx) mx = v2;
            if (v3 > mx) mx = v3;
            wd[2*ch +: 2] = enc((m == 2'd1) ? mx : (s >= 2) ? 1 : (s <= -2) ? -1 : 0);
          end
          exp_q.push_back(wd);
        end
    end
  endtask

  task automatic start_frame(input logic [1:0] m, input int w, input int h);
    mode = m; width = 7'(w); height = 7'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_px(input logic [DW-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: in_ready 0 want 1");
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [1:0] m, input int w, input int h, input bit chk_lat, input int n_out);
    int n = 0, c0;
    c0 = out_cnt;
    start_frame(m, w, h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) send_px(img[r][c]);
    in_valid = 1'b0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", DW'(done), DW'(1));
    if (chk_lat) check("done_latency", DW'(cyc - last_hs), DW'(1));
    @(negedge clk);
    check("out_count", DW'(out_cnt - c0), DW'(n_out));
    check("busy_after", DW'(busy), '0);
    check("usage_after", DW'(usage), '0);
    check("sb_empty", DW'(exp_q.size()), '0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_flags", DW'({busy, done, cfg_err, in_ready}), '0);
    check("rst_usage", DW'(usage), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bypass 4x2 ramp of legal codes: outputs equal inputs
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        for (int ch = 0; ch < N_CH; ch++) img[r][c][2*ch +: 2] = code4((r * 4 + c + ch) % 3);
        exp_q.push_back(img[r][c]);
      end
    run_frame(2'd0, 4, 2, 1'b1, 8);

    // Max 4x4: channel 0 all -1 except (1,1) = +1
    clear_img();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c][1:0] = 2'b11;
    img[1][1][1:0] = 2'b01;
    exp_q.push_back(DW'(2'b01));
    exp_q.push_back(DW'(2'b11));
    exp_q.push_back(DW'(2'b11));
    exp_q.push_back(DW'(2'b11));
    peak = 0;
    run_frame(2'd1, 4, 4, 1'b1, 4);
    check("usage_peak", DW'(peak), DW'(2));

    // Avg 2x2: S = 1 -> 0, S = 3 -> +1, S = -2 -> -1
    clear_img();
    img[0][0][1:0] = 2'b01; img[0][1][1:0] = 2'b01; img[1][0][1:0] = 2'b00; img[1][1][1:0] = 2'b11;
    exp_q.push_back(DW'(2'b00));
    run_frame(2'd2, 2, 2, 1'b1, 1);
    img[1][0][1:0] = 2'b01; img[1][1][1:0] = 2'b00;
    exp_q.push_back(DW'(2'b01));
    run_frame(2'd2, 2, 2, 1'b1, 1);
    img[0][0][1:0] = 2'b11; img[0][1][1:0] = 2'b11; img[1][0][1:0] = 2'b00;
    exp_q.push_back(DW'(2'b11));
    run_frame(2'd2, 2, 2, 1'b1, 1);

    // Max 5x3: odd column and odd row dropped
    fill_varied(1);
    model(2'd1, 5, 3);
    run_frame(2'd1, 5, 3, 1'b0, 2);

    // Avg 4x4 with all channels varied, including illegal 10 codes
    fill_varied(2);
    model(2'd2, 4, 4);
    run_frame(2'd2, 4, 4, 1'b1, 4);

    // Bypass 6x2 with a five-cycle downstream stall
    fill_varied(3);
    model(2'd0, 6, 2);
    fork
      run_frame(2'd0, 6, 2, 1'b1, 12);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    // Rejected configurations
    start_frame(2'd1, 65, 4);
    check("cfg_err_w65", DW'(cfg_err), DW'(1));
    check("busy_w65", DW'(busy), '0);
    @(negedge clk);
    check("cfg_err_pulse", DW'(cfg_err), '0);
    start_frame(2'd3, 4, 4);
    check("cfg_err_mode3", DW'(cfg_err), DW'(1));
    check("busy_mode3", DW'(busy), '0);
    @(negedge clk);

    // Reset in the middle of a max frame, then a clean frame
    fill_varied(4);
    start_frame(2'd1, 4, 4);
    for (int c = 0; c < 4; c++) send_px(img[0][c]);
    send_px(img[1][0]);
    in_valid = 1'b0;
    check("usage_mid", DW'(usage), DW'(2));
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", DW'({busy, done, cfg_err, in_ready, out_valid}), '0);
    check("mid_rst_usage", DW'(usage), '0);
    check("mid_rst_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_varied(5);
    model(2'd1, 4, 4);
    run_frame(2'd1, 4, 4, 1'b1, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
